// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the car-park exit controller.
//   FEE_W           : width of every fee / money quantity
//   RATE_DEFAULT    : default fee units charged per parked hour
//   MAX_FEE_DEFAULT : default ceiling on the computed fee
//   exit_state_t    : exit controller states
// -----------------------------------------------------------------------------
package parking_pkg;

  localparam int FEE_W           = 8;
  localparam int RATE_DEFAULT    = 2;
  localparam int MAX_FEE_DEFAULT = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICKET,
    S_PAY,
    S_OPEN,
    S_ALARM
  } exit_state_t;

endpackage

// File: rtl/parking_fee_calc.sv
// -----------------------------------------------------------------------------
// parking_fee_calc
// Combinational fee computation: hours * RATE, saturated at MAX_FEE.
// Optional macro PARKING_EXIT_GRACE_EN makes the first hour free
// (0 or 1 hour costs nothing, otherwise (hours-1) * RATE).
// Ports:
//   hours : in  4      parked hours from the ticket
//   fee   : out FEE_W  fee to collect
// -----------------------------------------------------------------------------
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int RATE    = RATE_DEFAULT,
  parameter int MAX_FEE = MAX_FEE_DEFAULT
) (
  input  logic [3:0]       hours,
  output logic [FEE_W-1:0] fee
);

  logic [3:0]  billable;
  logic [15:0] raw;

  always_comb begin
`ifdef PARKING_EXIT_GRACE_EN
    billable = (hours == 4'd0) ? 4'd0 : hours - 4'd1;
`else
    billable = hours;
`endif
    // 4-bit hours times a small rate cannot overflow 16 bits, so the
    // comparison against the ceiling is exact.
    raw = 16'(billable) * 16'(RATE);
    fee = (raw > 16'(MAX_FEE)) ? FEE_W'(MAX_FEE) : raw[FEE_W-1:0];
  end

endmodule

// File: rtl/parking_exit_gate.sv
// -----------------------------------------------------------------------------
// parking_exit_gate
// Exit-side car-park controller: reads the ticket, computes the fee, collects
// coins, returns change, opens the barrier and pulses car_exit once the car
// has cleared the gate. Payment or gate timeouts raise alarm.
// Optional macro PARKING_EXIT_GRACE_EN (inside parking_fee_calc): first hour free.
// Ports:
//   clk          : in  1  rising-edge clock
//   reset        : in  1  synchronous, active-high
//   car_at_exit  : in  1  car present on the exit loop (level)
//   ticket_valid : in  1  ticket read strobe
//   ticket_hours : in  4  parked hours, valid with ticket_valid
//   coin_valid   : in  1  coin inserted strobe
//   coin_value   : in  4  coin value, valid with coin_valid
//   car_passed   : in  1  post-gate sensor strobe
//   gate_open    : out 1  barrier open
//   fee_due      : out 8  remaining fee
//   change_valid : out 1  one-cycle strobe qualifying change_out
//   change_out   : out 8  amount returned
//   car_exit     : out 1  one-cycle pulse: car has left
//   alarm        : out 1  payment or gate timeout
// -----------------------------------------------------------------------------
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int RATE         = RATE_DEFAULT,
  parameter int MAX_FEE      = MAX_FEE_DEFAULT,
  parameter int PAY_TIMEOUT  = 16,
  parameter int GATE_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             car_at_exit,
  input  logic             ticket_valid,
  input  logic [3:0]       ticket_hours,
  input  logic             coin_valid,
  input  logic [3:0]       coin_value,
  input  logic             car_passed,
  output logic             gate_open,
  output logic [FEE_W-1:0] fee_due,
  output logic             change_valid,
  output logic [FEE_W-1:0] change_out,
  output logic             car_exit,
  output logic             alarm
);

  exit_state_t      state, state_nxt;
  logic [FEE_W-1:0] paid, paid_nxt;
  logic [7:0]       timer, timer_nxt;
  logic [FEE_W-1:0] fee_due_nxt, change_out_nxt;
  logic             change_valid_nxt, car_exit_nxt;
  logic [FEE_W-1:0] ticket_fee, coin_amt;

  assign coin_amt = FEE_W'(coin_value);

  parking_fee_calc #(
    .RATE    (RATE),
    .MAX_FEE (MAX_FEE)
  ) u_fee_calc (
    .hours (ticket_hours),
    .fee   (ticket_fee)
  );

  // NOTE: every variable gets a default before the case statement, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt        = state;
    fee_due_nxt      = fee_due;
    paid_nxt         = paid;
    timer_nxt        = '0;
    car_exit_nxt     = 1'b0;
    change_valid_nxt = 1'b0;
    change_out_nxt   = '0;

    // A coin that is not consumed as payment is handed straight back.
    if (coin_valid) begin
      change_valid_nxt = 1'b1;
      change_out_nxt   = coin_amt;
    end

    case (state)
      S_IDLE: begin
        if (car_at_exit) state_nxt = S_WAIT_TICKET;
      end

      S_WAIT_TICKET: begin
        if (!car_at_exit) begin
          state_nxt   = S_IDLE;
          fee_due_nxt = '0;
        end else if (ticket_valid) begin
          fee_due_nxt = ticket_fee;
          state_nxt   = (ticket_fee == '0) ? S_OPEN : S_PAY;
        end
      end

      S_PAY: begin
        timer_nxt = timer + 8'd1;
        if (!car_at_exit) begin
          // Abandon beats a simultaneous coin: return everything collected.
          state_nxt        = S_IDLE;
          fee_due_nxt      = '0;
          change_valid_nxt = coin_valid || (paid != '0);
          change_out_nxt   = paid + (coin_valid ? coin_amt : '0);
        end else if (coin_valid) begin
          if (coin_amt < fee_due) begin
            fee_due_nxt      = fee_due - coin_amt;
            paid_nxt         = paid + coin_amt;
            timer_nxt        = '0;
            change_valid_nxt = 1'b0;
            change_out_nxt   = '0;
          end else begin
            change_out_nxt = coin_amt - fee_due;
            fee_due_nxt    = '0;
            state_nxt      = S_OPEN;
          end
        end else if (timer == 8'(PAY_TIMEOUT - 1)) begin
          state_nxt = S_ALARM;
        end
      end

      S_OPEN: begin
        timer_nxt = timer + 8'd1;
        if (car_passed) begin
          car_exit_nxt = 1'b1;
          state_nxt    = S_IDLE;
        end else if (timer == 8'(GATE_TIMEOUT - 1)) begin
          state_nxt = S_ALARM;
        end
      end

      S_ALARM: begin
        if (!car_at_exit) begin
          state_nxt   = S_IDLE;
          fee_due_nxt = '0;
        end
      end

      default: begin
        state_nxt   = S_IDLE;
        fee_due_nxt = '0;
      end
    endcase

    // The timer restarts on every state entry; money collected only matters
    // while the car is still paying.
    if (state_nxt != state) timer_nxt = '0;
    if (state_nxt != S_PAY) paid_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      paid         <= '0;
      timer        <= '0;
      gate_open    <= 1'b0;
      fee_due      <= '0;
      change_valid <= 1'b0;
      change_out   <= '0;
      car_exit     <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      state        <= state_nxt;
      paid         <= paid_nxt;
      timer        <= timer_nxt;
      gate_open    <= (state_nxt == S_OPEN);
      fee_due      <= fee_due_nxt;
      change_valid <= change_valid_nxt;
      change_out   <= change_out_nxt;
      car_exit     <= car_exit_nxt;
      alarm        <= (state_nxt == S_ALARM);
    end
  end

endmodule

// File: tb/tb_parking_exit_gate.sv
// -----------------------------------------------------------------------------
// tb_parking_exit_gate
// Self-checking bench for parking_exit_gate: directed scenarios followed by
// randomized exit sessions checked against a session-level payment model.
// -----------------------------------------------------------------------------
module tb_parking_exit_gate;

  localparam int RATE    = 2;
  localparam int MAX_FEE = 15;
`ifdef PARKING_EXIT_GRACE_EN
  localparam logic [3:0] H_FEE6 = 4'd4;
  localparam logic [3:0] H_FEE8 = 4'd5;
`else
  localparam logic [3:0] H_FEE6 = 4'd3;
  localparam logic [3:0] H_FEE8 = 4'd4;
`endif

  logic       clk = 1'b0;
  logic       reset, car_at_exit, ticket_valid, coin_valid, car_passed;
  logic [3:0] ticket_hours, coin_value;
  logic       gate_open, change_valid, car_exit, alarm;
  logic [7:0] fee_due, change_out;

  int n_tests = 0;
  int n_fail  = 0;

  int fee, remaining, paid, c, gap, n_coins, refund;
  bit abandon, done, opened, with_coin, seen_exit;

  parking_exit_gate dut (
    .clk          (clk),
    .reset        (reset),
    .car_at_exit  (car_at_exit),
    .ticket_valid (ticket_valid),
    .ticket_hours (ticket_hours),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .car_passed   (car_passed),
    .gate_open    (gate_open),
    .fee_due      (fee_due),
    .change_valid (change_valid),
    .change_out   (change_out),
    .car_exit     (car_exit),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  // Fee rule: hours * RATE (first hour free with grace), capped at MAX_FEE.
  function automatic int exp_fee(input int hours);
    int billable;
`ifdef PARKING_EXIT_GRACE_EN
    billable = (hours > 0) ? hours - 1 : 0;
`else
    billable = hours;
`endif
    return (billable * RATE > MAX_FEE) ? MAX_FEE : billable * RATE;
  endfunction

  // One clock edge; outputs are sampled 1 time unit later, strobes dropped.
  task automatic step();
    @(posedge clk);
    #1;
    ticket_valid = 1'b0;
    coin_valid   = 1'b0;
    car_passed   = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gate"},   gate_open,    0);
    check({tag, "_fee"},    fee_due,      0);
    check({tag, "_chg_v"},  change_valid, 0);
    check({tag, "_chg"},    change_out,   0);
    check({tag, "_exit"},   car_exit,     0);
    check({tag, "_alarm"},  alarm,        0);
  endtask

  initial begin
    reset = 1'b1; car_at_exit = 1'b0; ticket_valid = 1'b0; ticket_hours = '0;
    coin_valid = 1'b0; coin_value = '0; car_passed = 1'b0;
    step(); step();
    reset = 1'b0;
    check_quiet("reset");

    // ---- normal exit ----
    car_at_exit = 1'b1; step();
    ticket_valid = 1'b1; ticket_hours = H_FEE6; step();
    check("norm_fee", fee_due, 6);
    check("norm_gate_closed", gate_open, 0);
    coin_valid = 1'b1; coin_value = 4'd5; step();
    check("norm_fee_after_coin", fee_due, 1);
    check("norm_no_change", change_valid, 0);
    coin_valid = 1'b1; coin_value = 4'd5; step();
    check("norm_chg_v", change_valid, 1);
    check("norm_chg", change_out, 4);
    check("norm_gate_open", gate_open, 1);
    check("norm_fee_zero", fee_due, 0);
    step();
    check("norm_chg_strobe", change_valid, 0);
    check("norm_gate_held", gate_open, 1);
    car_passed = 1'b1; car_at_exit = 1'b0; step();
    check("norm_exit", car_exit, 1);
    check("norm_gate_fall", gate_open, 0);
    step();
    check("norm_exit_pulse", car_exit, 0);

    // ---- saturation ----
    car_at_exit = 1'b1; step();
    ticket_valid = 1'b1; ticket_hours = 4'd15; step();
    check("sat_fee", fee_due, 15);
    car_at_exit = 1'b0; step();
    check("sat_leave_fee", fee_due, 0);
    check("sat_leave_chg_v", change_valid, 0);

`ifdef PARKING_EXIT_GRACE_EN
    car_at_exit = 1'b1; step();
    ticket_valid = 1'b1; ticket_hours = 4'd1; step();
    check("grace_open", gate_open, 1);
    check("grace_fee", fee_due, 0);
    car_passed = 1'b1; car_at_exit = 1'b0; step();
    check("grace_exit", car_exit, 1);
`endif

    // ---- abandon with refund ----
    car_at_exit = 1'b1; step();
    ticket_valid = 1'b1; ticket_hours = H_FEE8; step();
    check("aband_fee", fee_due, 8);
    coin_valid = 1'b1; coin_value = 4'd3; step();
    check("aband_fee_coin", fee_due, 5);
    car_at_exit = 1'b0; step();
    check("aband_chg_v", change_valid, 1);
    check("aband_chg", change_out, 3);
    check("aband_fee_clr", fee_due, 0);
    step();
    check("aband_idle_gate", gate_open, 0);

    // ---- pay timeout ----
    car_at_exit = 1'b1; step();
    ticket_valid = 1'b1; ticket_hours = H_FEE6; step();
    repeat (15) step();
    check("payto_not_yet", alarm, 0);
    step();
    check("payto_alarm", alarm, 1);
    check("payto_gate", gate_open, 0);
    check("payto_fee_kept", fee_due, 6);
    car_at_exit = 1'b0; step();
    check("payto_clear_alarm", alarm, 0);
    check("payto_clear_fee", fee_due, 0);

    // ---- gate timeout ----
    car_at_exit = 1'b1; step();
    ticket_valid = 1'b1; ticket_hours = H_FEE6; step();
    coin_valid = 1'b1; coin_value = 4'd6; step();
    check("gateto_chg_v", change_valid, 1);
    check("gateto_chg_zero", change_out, 0);
    check("gateto_open", gate_open, 1);
    seen_exit = 1'b0;
    repeat (7) begin step(); seen_exit |= car_exit; end
    check("gateto_still_open", gate_open, 1);
    check("gateto_no_alarm_yet", alarm, 0);
    step(); seen_exit |= car_exit;
    check("gateto_alarm", alarm, 1);
    check("gateto_closed", gate_open, 0);
    check("gateto_no_exit", seen_exit, 0);
    car_at_exit = 1'b0; step();
    check("gateto_idle", alarm, 0);

    // ---- reset while open, then stray coin ----
    car_at_exit = 1'b1; step();
    ticket_valid = 1'b1; ticket_hours = 4'd0; step();
    check("rst_open", gate_open, 1);
    reset = 1'b1; car_passed = 1'b1; step();
    reset = 1'b0; car_at_exit = 1'b0;
    check_quiet("rst_mid");
    step();
    check("rst_no_exit", car_exit, 0);
    coin_valid = 1'b1; coin_value = 4'd7; step();
    check("stray_chg_v", change_valid, 1);
    check("stray_chg", change_out, 7);
    check("stray_gate", gate_open, 0);

    // ---- randomized sessions ----
    for (int s = 0; s < 40; s++) begin
      car_at_exit = 1'b1; step();
      ticket_hours = 4'($urandom_range(0, 15));
      fee = exp_fee(int'(ticket_hours));
      ticket_valid = 1'b1; step();
      opened = 1'b0;
      if (fee == 0) begin
        check("rnd_free_open", gate_open, 1);
        check("rnd_free_fee", fee_due, 0);
        opened = 1'b1;
      end else begin
        check("rnd_fee", fee_due, fee);
        remaining = fee; paid = 0; n_coins = 0; done = 1'b0;
        abandon = ($urandom_range(0, 3) == 0);
        while (!done) begin
          gap = $urandom_range(0, 3);
          repeat (gap) step();
          c = (n_coins >= 20) ? 15 : $urandom_range(0, 9);
          n_coins++;
          if (abandon && $urandom_range(0, 2) == 0) begin
            with_coin = 1'($urandom_range(0, 1));
            car_at_exit = 1'b0; coin_valid = with_coin; coin_value = 4'(c);
            step();
            refund = paid + (with_coin ? c : 0);
            check("rnd_refund_v", change_valid, (paid > 0) || with_coin);
            if ((paid > 0) || with_coin) check("rnd_refund", change_out, refund);
            check("rnd_aband_fee", fee_due, 0);
            check("rnd_aband_gate", gate_open, 0);
            done = 1'b1;
          end else begin
            coin_valid = 1'b1; coin_value = 4'(c); step();
            if (c < remaining) begin
              remaining -= c;
              paid += c;
              check("rnd_fee_left", fee_due, remaining);
              check("rnd_no_chg", change_valid, 0);
            end else begin
              check("rnd_chg_v", change_valid, 1);
              check("rnd_chg", change_out, c - remaining);
              check("rnd_open", gate_open, 1);
              check("rnd_paid_fee", fee_due, 0);
              opened = 1'b1;
              done = 1'b1;
            end
          end
        end
      end
      if (opened) begin
        repeat ($urandom_range(0, 5)) step();
        car_passed = 1'b1; car_at_exit = 1'b0; step();
        check("rnd_exit", car_exit, 1);
        check("rnd_gate_fall", gate_open, 0);
        step();
        check("rnd_exit_pulse", car_exit, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_exit_gate.md
# parking_exit_gate

Exit-side controller for the car park: the counterpart to the entry/password gate. It reads the parked duration from the presented ticket, computes the fee, collects coins and returns change, then opens the barrier. Once the car clears the gate it issues a one-cycle `car_exit` pulse, which drives the occupancy counter's `car_exit` input.

## Interface
- `RATE`, 2: fee units per parked hour
- `MAX_FEE`, 15: fee saturation ceiling
- `PAY_TIMEOUT`, 16: cycles allowed between ticket/coin events in PAY
- `GATE_TIMEOUT`, 8: cycles the gate stays open waiting for `car_passed`
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `car_at_exit`  in  1  level; car present on exit loop
- `ticket_valid`  in  1  strobe; ticket read this cycle
- `ticket_hours`  in  4  parked hours, valid with `ticket_valid`
- `coin_valid`  in  1  strobe; coin inserted
- `coin_value`  in  4  coin value, valid with `coin_valid`
- `car_passed`  in  1  strobe from post-gate sensor
- `gate_open`  out  1  barrier open
- `fee_due`  out  8  remaining fee
- `change_valid`  out  1  one-cycle strobe
- `change_out`  out  8  amount returned, valid with `change_valid`
- `car_exit`  out  1  one-cycle pulse: car has left
- `alarm`  out  1  payment or gate timeout

## Operation
- States: IDLE, WAIT_TICKET, PAY, OPEN, ALARM. Internal registers: `paid` (8 bit), `timer` (8 bit).
- IDLE -> WAIT_TICKET when `car_at_exit`=1.
- WAIT_TICKET: on `ticket_valid`, compute fee = min(`ticket_hours`*`RATE`, `MAX_FEE`) in 8 bits, load `fee_due`, clear `paid`. Fee 0 -> OPEN; otherwise -> PAY.
- PAY, `coin_valid`:
  - `coin_value` < `fee_due`: `fee_due` -= coin, `paid` += coin, `timer` restarts.
  - `coin_value` >= `fee_due`: `change_out` = coin - `fee_due`, `change_valid`=1 (also when change is 0), `fee_due`=0, -> OPEN.
- PAY: `timer` reaching `PAY_TIMEOUT` -> ALARM, `fee_due` unchanged.
- OPEN: `gate_open`=1, `timer` counts. On `car_passed`: `car_exit`=1 for one cycle, `gate_open`=0, -> IDLE. `timer` reaching `GATE_TIMEOUT` -> ALARM, no `car_exit`.
- ALARM: `alarm`=1, `gate_open`=0. Stays in ALARM until `car_at_exit`=0, then -> IDLE, `fee_due`=0.
- Abandon: `car_at_exit`=0 in WAIT_TICKET or PAY -> IDLE. If `paid`>0, refund it: `change_out`=`paid`, `change_valid`=1. Clear `fee_due` and `paid`.
- Coin outside PAY: refunded in full next cycle (`change_out`=`coin_value`), state unchanged.
- Ignored: `ticket_valid` outside WAIT_TICKET; `car_passed` outside OPEN.
- Simultaneous abandon and `coin_valid` in PAY: abandon wins; refund = `paid` + `coin_value`.

## Timing
- Every output is registered. Reset values: `gate_open`=0, `fee_due`=0, `change_valid`=0, `change_out`=0, `car_exit`=0, `alarm`=0, state IDLE.
- `fee_due` is valid 1 cycle after `ticket_valid`. Coin effects and change appear 1 cycle after `coin_valid`.
- `gate_open` rises on the edge that enters OPEN. It falls on the same edge that asserts `car_exit`, 1 cycle after `car_passed`.
- `timer` clears on every state entry and on each accepted coin. The timeout fires on the cycle `timer` == limit-1.
- `reset` in any state, including OPEN mid-exit: immediate return to reset values. No `car_exit` and no refund are emitted.

## Configuration
- `PARKING_EXIT_GRACE_EN`: when defined, the first hour is free: fee = min((`ticket_hours`-1)*`RATE`, `MAX_FEE`), and `ticket_hours` of 0 or 1 gives fee 0.
- When undefined: fee = min(`ticket_hours`*`RATE`, `MAX_FEE`).

## Structure
- Shared `parking_pkg` holds:
  - the exit state enum;
  - `FEE_W`=8;
  - the `RATE` and `MAX_FEE` defaults.
- One sub-module, `parking_fee_calc`: combinational multiply, saturate and grace adjustment. It is instantiated once, in WAIT_TICKET's datapath.

## Test plan
- Normal exit, grace off, `RATE`=2: hours=3 -> `fee_due`=6. Coin 5 -> `fee_due`=1. Coin 5 -> `change_out`=4 and `gate_open`=1. `car_passed` -> `car_exit` pulses for 1 cycle, `gate_open`=0.
- Saturation: hours=15 -> `fee_due`=15. With `PARKING_EXIT_GRACE_EN` defined, hours=1 -> gate opens directly with no PAY.
- Abandon: hours=4 (fee 8), coin 3, drop `car_at_exit` -> `change_out`=3, IDLE, `fee_due`=0.
- Pay timeout: fee 6, no coins for 16 cycles -> `alarm`=1, `gate_open`=0. `car_at_exit`=0 -> IDLE, `alarm`=0.
- Gate timeout: exact payment, no `car_passed` for 8 cycles -> ALARM, `car_exit` never asserted.
- Reset while OPEN -> next cycle all outputs 0, state IDLE. Stray coin in IDLE, value 7 -> `change_out`=7.
